// File: rtl/utm_pkg.sv
// Shared types and constants for the universal Turing machine run controller.
package utm_pkg;
    localparam int SYM_W   = 3;
    localparam int STATE_W = 8;
    localparam int STEP_W  = 16;

    localparam logic [STATE_W-1:0] HALT_STATE = 8'h00;

    localparam logic [SYM_W-1:0] SYM_BLANK = 3'b000;
    localparam logic [SYM_W-1:0] SYM_1     = 3'b001;
    localparam logic [SYM_W-1:0] SYM_2     = 3'b010;
    localparam logic [SYM_W-1:0] SYM_4     = 3'b100;
    localparam logic [SYM_W-1:0] SYM_5     = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_DONE
    } seq_state_t;

    function automatic logic is_one_hot(input logic [STATE_W-1:0] s);
        return (s != '0) && ((s & (s - 1'b1)) == '0);
    endfunction
endpackage

// File: rtl/utm_tape.sv
// Tape register file: one write port, a head-side read port and a host readback port.
module utm_tape
    import utm_pkg::*;
#(
    parameter int TAPE_LEN = 16,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [SYM_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [SYM_W-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [SYM_W-1:0]  rdata_b
);
    logic [SYM_W-1:0] cells [TAPE_LEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPE_LEN; i++) cells[i] <= SYM_BLANK;
        end else if (we && (int'(waddr) < TAPE_LEN)) begin
            cells[waddr] <= wdata;
        end
    end

    // Addresses past the end of a short tape read as blank.
    assign rdata_a = (int'(raddr_a) < TAPE_LEN) ? cells[raddr_a] : SYM_BLANK;
    assign rdata_b = (int'(raddr_b) < TAPE_LEN) ? cells[raddr_b] : SYM_BLANK;
endmodule

// File: rtl/utm_sequencer.sv
// Run controller: owns tape, head and machine state, and steps the external
// transition logic one FETCH/EXEC pair at a time until halt, fault or step limit.
//
//   state    | meaning
//   ST_IDLE  | after reset; host may load tape, start begins a run
//   ST_FETCH | latch tape[head] into the symbol register
//   ST_EXEC  | sample transition outputs, commit write/state/head/steps
//   ST_DONE  | run ended; flags held, host may load or restart
module utm_sequencer
    import utm_pkg::*;
#(
    parameter int                  TAPE_LEN    = 16,
    parameter int                  ADDR_W      = 4,
    parameter logic [STATE_W-1:0]  START_STATE = 8'h01,
    parameter logic [ADDR_W-1:0]   START_HEAD  = '0,
    parameter logic [STEP_W-1:0]   MAX_STEPS   = 16'hFFFF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [SYM_W-1:0]   load_sym,
    output logic [SYM_W-1:0]   rd_sym,
    output logic [STATE_W-1:0] tr_state,
    output logic               tr_s2,
    output logic               tr_s1,
    output logic               tr_s0,
    input  logic [STATE_W-1:0] tr_next_state,
    input  logic [SYM_W-1:0]   tr_write_sym,
    input  logic               tr_move_right,
    output logic               busy,
    output logic               done,
    output logic               fault,
    output logic               timeout,
    output logic [ADDR_W-1:0]  head,
    output logic [STEP_W-1:0]  steps
);
    localparam logic [ADDR_W-1:0] HEAD_LAST = ADDR_W'(TAPE_LEN - 1);

    seq_state_t         state_q, state_d;
    logic [STATE_W-1:0] mstate_q, mstate_d;
    logic [ADDR_W-1:0]  head_q, head_d;
    logic [SYM_W-1:0]   sym_q, sym_d;
    logic [STEP_W-1:0]  steps_q, steps_d, steps_inc;
    logic               fault_q, fault_d;
    logic               timeout_q, timeout_d;

    logic               tape_we;
    logic [ADDR_W-1:0]  tape_waddr;
    logic [SYM_W-1:0]   tape_wdata;
    logic [SYM_W-1:0]   head_sym;
    logic               off_tape;

    assign steps_inc = steps_q + 1'b1;
    assign off_tape  = tr_move_right ? (head_q == HEAD_LAST) : (head_q == '0);

    always_comb begin
        state_d    = state_q;
        mstate_d   = mstate_q;
        head_d     = head_q;
        sym_d      = sym_q;
        steps_d    = steps_q;
        fault_d    = fault_q;
        timeout_d  = timeout_q;
        tape_we    = 1'b0;
        tape_waddr = load_addr;
        tape_wdata = load_sym;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                tape_we = load_en;
                if (start) begin
                    state_d   = ST_FETCH;
                    mstate_d  = START_STATE;
                    head_d    = START_HEAD;
                    steps_d   = '0;
                    fault_d   = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            ST_FETCH: begin
                sym_d   = head_sym;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d    = ST_DONE;
                tape_waddr = head_q;
                tape_wdata = tr_write_sym;
                if (tr_next_state == HALT_STATE) begin
                    tape_we = 1'b1;
                    steps_d = steps_inc;
                end else if (!is_one_hot(tr_next_state)) begin
                    fault_d = 1'b1;
                end else begin
                    tape_we  = 1'b1;
                    mstate_d = tr_next_state;
                    steps_d  = steps_inc;
                    if (off_tape) begin
                        fault_d = 1'b1;
                    end else begin
                        head_d = tr_move_right ? head_q + 1'b1 : head_q - 1'b1;
                        if (steps_inc == MAX_STEPS) timeout_d = 1'b1;
                        else                        state_d   = ST_FETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mstate_q  <= START_STATE;
            head_q    <= START_HEAD;
            sym_q     <= SYM_BLANK;
            steps_q   <= '0;
            fault_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mstate_q  <= mstate_d;
            head_q    <= head_d;
            sym_q     <= sym_d;
            steps_q   <= steps_d;
            fault_q   <= fault_d;
            timeout_q <= timeout_d;
        end
    end

    utm_tape #(
        .TAPE_LEN (TAPE_LEN),
        .ADDR_W   (ADDR_W)
    ) u_tape (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (tape_we),
        .waddr   (tape_waddr),
        .wdata   (tape_wdata),
        .raddr_a (head_q),
        .rdata_a (head_sym),
        .raddr_b (load_addr),
        .rdata_b (rd_sym)
    );

    assign tr_state              = mstate_q;
    assign {tr_s2, tr_s1, tr_s0} = sym_q;
    assign busy                  = (state_q == ST_FETCH) || (state_q == ST_EXEC);
    assign done                  = (state_q == ST_DONE);
    assign fault                 = fault_q;
    assign timeout               = timeout_q;
    assign head                  = head_q;
    assign steps                 = steps_q;
endmodule

// File: tb/tb_utm_sequencer.sv
// Scoreboard bench for utm_sequencer: directed runs against stub transition tables.
module tb_utm_sequencer;
    import utm_pkg::*;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        fault;
        logic        timeout;
        logic [3:0]  head;
        logic [15:0] steps;
        logic [7:0]  tr_state;
        logic [2:0]  sym;
        logic [2:0]  rd_sym;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  exp;
        bit    chk_lat;
        int    lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start_a = 0, load_en_a = 0, chk_a = 0;
    logic [3:0] load_addr_a = 0;
    logic [2:0] load_sym_a = 0, rd_sym_a;
    logic [7:0] tr_state_a, tr_next_a;
    logic       tr_s2_a, tr_s1_a, tr_s0_a, tr_right_a;
    logic [2:0] tr_wsym_a;
    logic       busy_a, done_a, fault_a, timeout_a;
    logic [3:0] head_a;
    logic [15:0] steps_a;

    logic       start_b = 0, load_en_b = 0, chk_b = 0;
    logic [3:0] load_addr_b = 0;
    logic [2:0] load_sym_b = 0, rd_sym_b;
    logic [7:0] tr_state_b, tr_next_b;
    logic       tr_s2_b, tr_s1_b, tr_s0_b, tr_right_b;
    logic [2:0] tr_wsym_b;
    logic       busy_b, done_b, fault_b, timeout_b;
    logic [3:0] head_b;
    logic [15:0] steps_b;

    int mode_a = 0;

    // 0: halt, 1: march right in state B, 2: non-one-hot, else: ping-pong head 0<->1
    function automatic logic [11:0] stub(input int mode, input logic [7:0] st);
        case (mode)
            0:       return {8'h00, SYM_5, 1'b1};
            1:       return {8'h02, SYM_1, 1'b1};
            2:       return {8'h03, SYM_4, 1'b1};
            default: return (st == 8'h01) ? {8'h02, SYM_2, 1'b1} : {8'h01, SYM_4, 1'b0};
        endcase
    endfunction

    assign {tr_next_a, tr_wsym_a, tr_right_a} = stub(mode_a, tr_state_a);
    assign {tr_next_b, tr_wsym_b, tr_right_b} = stub(3, tr_state_b);

    utm_sequencer dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .load_en(load_en_a),
        .load_addr(load_addr_a), .load_sym(load_sym_a), .rd_sym(rd_sym_a),
        .tr_state(tr_state_a), .tr_s2(tr_s2_a), .tr_s1(tr_s1_a), .tr_s0(tr_s0_a),
        .tr_next_state(tr_next_a), .tr_write_sym(tr_wsym_a), .tr_move_right(tr_right_a),
        .busy(busy_a), .done(done_a), .fault(fault_a), .timeout(timeout_a),
        .head(head_a), .steps(steps_a)
    );

    utm_sequencer #(.MAX_STEPS(16'd5)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .load_en(load_en_b),
        .load_addr(load_addr_b), .load_sym(load_sym_b), .rd_sym(rd_sym_b),
        .tr_state(tr_state_b), .tr_s2(tr_s2_b), .tr_s1(tr_s1_b), .tr_s0(tr_s0_b),
        .tr_next_state(tr_next_b), .tr_write_sym(tr_wsym_b), .tr_move_right(tr_right_b),
        .busy(busy_b), .done(done_b), .fault(fault_b), .timeout(timeout_b),
        .head(head_b), .steps(steps_b)
    );

    obs_t obs_a, obs_b;
    assign obs_a = {busy_a, done_a, fault_a, timeout_a, head_a, steps_a, tr_state_a,
                    tr_s2_a, tr_s1_a, tr_s0_a, rd_sym_a};
    assign obs_b = {busy_b, done_b, fault_b, timeout_b, head_b, steps_b, tr_state_b,
                    tr_s2_b, tr_s1_b, tr_s0_b, rd_sym_b};

    exp_t q_a[$], q_b[$];
    int   rd_a = 0, rd_b = 0;
    int   n_checks = 0, n_fail = 0;
    int   cyc = 0, start_cyc_a = 0, start_cyc_b = 0;
    bit   fin = 0, fin_seen = 0;
    logic done_prev_a = 0, done_prev_b = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t mk(input logic busy, input logic done, input logic flt,
                                input logic tmo, input logic [3:0] hd, input logic [15:0] st,
                                input logic [7:0] ms, input logic [2:0] sym, input logic [2:0] rd);
        return {busy, done, flt, tmo, hd, st, ms, sym, rd};
    endfunction

    task automatic cmp(input exp_t e, input obs_t act, input int lat);
        n_checks++;
        if (act !== e.exp || (e.chk_lat && lat != e.lat)) begin
            n_fail++;
            $display("FAIL %s: got obs=%h lat=%0d, expected obs=%h lat=%0d",
                     e.tag, act, lat, e.exp, e.lat);
        end
    endtask

    // Monitor: pops an expectation on each done rising edge or explicit check strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_a || (done_a && !done_prev_a)) begin
                if (rd_a < q_a.size()) begin
                    cmp(q_a[rd_a], obs_a, cyc - start_cyc_a);
                    rd_a++;
                end else begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_a: no expectation queued, got obs=%h", obs_a);
                end
            end
            if (chk_b || (done_b && !done_prev_b)) begin
                if (rd_b < q_b.size()) begin
                    cmp(q_b[rd_b], obs_b, cyc - start_cyc_b);
                    rd_b++;
                end else begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_b: no expectation queued, got obs=%h", obs_b);
                end
            end
            done_prev_a = done_a;
            done_prev_b = done_b;
            if (fin && !fin_seen) begin
                fin_seen = 1;
                n_checks++;
                if (rd_a != q_a.size() || rd_b != q_b.size()) begin
                    n_fail++;
                    $display("FAIL drain: consumed %0d/%0d and %0d/%0d, required all",
                             rd_a, q_a.size(), rd_b, q_b.size());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_a(input string tag, input obs_t e, input bit cl, input int lat);
        q_a.push_back('{tag, e, cl, lat});
    endtask

    task automatic expect_b(input string tag, input obs_t e, input bit cl, input int lat);
        q_b.push_back('{tag, e, cl, lat});
    endtask

    task automatic check_a(input string tag, input obs_t e);
        expect_a(tag, e, 1'b0, 0);
        chk_a = 1;
        tick;
        chk_a = 0;
    endtask

    task automatic check_b(input string tag, input obs_t e);
        expect_b(tag, e, 1'b0, 0);
        chk_b = 1;
        tick;
        chk_b = 0;
    endtask

    task automatic pulse_start_a;
        start_a = 1;
        start_cyc_a = cyc;
        tick;
        start_a = 0;
    endtask

    // On an expired bound, strobe a check so the pending done expectation is compared and fails.
    task automatic wait_done_a(input int limit);
        int n = 0;
        while (!done_a && n < limit) begin
            tick;
            n++;
        end
        if (!done_a) begin
            chk_a = 1;
            tick;
            chk_a = 0;
        end
        tick;
    endtask

    task automatic wait_done_b(input int limit);
        int n = 0;
        while (!done_b && n < limit) begin
            tick;
            n++;
        end
        if (!done_b) begin
            chk_b = 1;
            tick;
            chk_b = 0;
        end
        tick;
    endtask

    task automatic load_a(input logic [3:0] addr, input logic [2:0] sym);
        load_en_a   = 1;
        load_addr_a = addr;
        load_sym_a  = sym;
        tick;
        load_en_a = 0;
    endtask

    logic [2:0] vals [4];
    obs_t       march_end;

    initial begin
        vals[0] = SYM_1;
        vals[1] = SYM_2;
        vals[2] = SYM_4;
        vals[3] = SYM_5;
        repeat (3) tick;
        rst_n = 1;
        tick;

        // Reset state and tape loading
        load_addr_a = 0;
        load_addr_b = 0;
        check_b("reset_b", mk(0, 0, 0, 0, 4'd0, 16'd0, 8'h01, SYM_BLANK, SYM_BLANK));
        check_a("reset_a", mk(0, 0, 0, 0, 4'd0, 16'd0, 8'h01, SYM_BLANK, SYM_BLANK));
        for (int i = 0; i < 4; i++) load_a(4'(i), vals[i]);
        for (int i = 0; i < 4; i++) begin
            load_addr_a = 4'(i);
            check_a($sformatf("load%0d", i), mk(0, 0, 0, 0, 4'd0, 16'd0, 8'h01, SYM_BLANK, vals[i]));
        end

        // Single-step normal halt
        mode_a = 0;
        load_addr_a = 0;
        expect_a("halt_run", mk(0, 1, 0, 0, 4'd0, 16'd1, 8'h01, SYM_1, SYM_5), 1'b1, 3);
        pulse_start_a;
        wait_done_a(20);

        // March right across a blank tape until the move falls off the end
        for (int i = 0; i < 4; i++) load_a(4'(i), SYM_BLANK);
        mode_a = 1;
        load_addr_a = 15;
        march_end = mk(0, 1, 1, 0, 4'd15, 16'd16, 8'h02, SYM_BLANK, SYM_1);
        expect_a("march_run", march_end, 1'b1, 33);
        pulse_start_a;
        wait_done_a(60);
        for (int i = 0; i < 16; i++) begin
            load_addr_a = 4'(i);
            check_a($sformatf("march_tape%0d", i), march_end);
        end

        // Non-one-hot next state: fault with no commit
        mode_a = 2;
        load_addr_a = 0;
        expect_a("bad_state", mk(0, 1, 1, 0, 4'd0, 16'd0, 8'h01, SYM_1, SYM_1), 1'b1, 3);
        pulse_start_a;
        wait_done_a(20);
        load_addr_a = 1;
        check_a("bad_state_tape1", mk(0, 1, 1, 0, 4'd0, 16'd0, 8'h01, SYM_1, SYM_1));

        // Step limit of 5 on a ping-pong machine, with ignored host pulses mid-run
        load_addr_b = 0;
        expect_b("busy_fetch", mk(1, 0, 0, 0, 4'd0, 16'd0, 8'h01, SYM_BLANK, SYM_BLANK), 1'b0, 0);
        expect_b("timeout_run", mk(0, 1, 0, 1, 4'd1, 16'd5, 8'h02, SYM_2, SYM_2), 1'b1, 11);
        start_b = 1;
        start_cyc_b = cyc;
        tick;
        start_b = 0;
        chk_b = 1;
        tick;
        chk_b = 0;
        tick;
        load_en_b   = 1;
        load_addr_b = 5;
        load_sym_b  = SYM_5;
        start_b     = 1;
        tick;
        load_en_b   = 0;
        start_b     = 0;
        load_addr_b = 0;
        wait_done_b(40);
        load_addr_b = 5;
        check_b("ignored_load", mk(0, 1, 0, 1, 4'd1, 16'd5, 8'h02, SYM_2, SYM_BLANK));
        load_addr_b = 1;
        check_b("pingpong_tape1", mk(0, 1, 0, 1, 4'd1, 16'd5, 8'h02, SYM_2, SYM_4));

        // Reset in the middle of step 3, then a fresh run
        mode_a = 3;
        load_addr_a = 0;
        pulse_start_a;
        repeat (4) tick;
        check_a("pre_reset", mk(1, 0, 0, 0, 4'd0, 16'd2, 8'h01, SYM_1, SYM_2));
        rst_n = 0;
        check_a("mid_reset", mk(0, 0, 0, 0, 4'd0, 16'd0, 8'h01, SYM_BLANK, SYM_BLANK));
        load_addr_a = 1;
        check_a("reset_tape1", mk(0, 0, 0, 0, 4'd0, 16'd0, 8'h01, SYM_BLANK, SYM_BLANK));
        load_addr_a = 15;
        check_a("reset_tape15", mk(0, 0, 0, 0, 4'd0, 16'd0, 8'h01, SYM_BLANK, SYM_BLANK));
        rst_n = 1;
        tick;
        mode_a = 0;
        load_addr_a = 0;
        expect_a("restart", mk(0, 1, 0, 0, 4'd0, 16'd1, 8'h01, SYM_BLANK, SYM_5), 1'b1, 3);
        pulse_start_a;
        wait_done_a(20);

        fin = 1;
        tick;
        tick;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/utm_sequencer.md
# utm_sequencer

Run controller for the universal Turing machine. It owns the tape register file, the head pointer and the one-hot machine-state register. It sequences the combinational transition logic (the `next_state` table plus write-symbol/move outputs) one step at a time until halt, fault or step limit. It sits between the host/IO pins, which load the tape and start the run, and the transition logic, which it drives with the current state and symbol.

## Interface
- `TAPE_LEN`, 16: number of tape cells.
- `ADDR_W`, 4: head/address width; `2**ADDR_W >= TAPE_LEN`.
- `START_STATE`, 8'h01: one-hot state loaded on start (state A).
- `START_HEAD`, 0: head position loaded on start.
- `MAX_STEPS`, 16'hFFFF: step limit before timeout halt.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; begins a run when not busy.
- `load_en` in 1: write `load_sym` to tape cell `load_addr`; honoured only when not busy.
- `load_addr` in ADDR_W: tape address for loading and readback.
- `load_sym` in 3: symbol {s2,s1,s0}.
- `rd_sym` out 3: combinational readback of tape[`load_addr`].
- `tr_state` out 8: current one-hot state to the transition logic.
- `tr_s2`, `tr_s1`, `tr_s0` out 1 each: latched current symbol.
- `tr_next_state` in 8: next state from the transition logic; 8'h00 means halt.
- `tr_write_sym` in 3: symbol to write under the head.
- `tr_move_right` in 1: 1 moves the head right, 0 moves it left.
- `busy` out 1: run in progress.
- `done` out 1: run ended; held until the next start.
- `fault` out 1: run ended abnormally (off-tape move or non-one-hot next state).
- `timeout` out 1: run ended by the step limit.
- `head` out ADDR_W: current head position.
- `steps` out 16: completed-step count.

## Operation
- FSM states: IDLE, FETCH, EXEC, DONE.
- IDLE:
  - `start` moves to FETCH, loads `START_STATE`/`START_HEAD`, and clears `steps`, `done`, `fault` and `timeout`.
  - `load_en` writes the tape.
- FETCH: latch tape[head] into the symbol register, which drives `tr_s2..0`. Go to EXEC.
- EXEC: the transition inputs are stable, so sample `tr_*` and then:
  - If `tr_next_state` == 0: write the symbol, leave the head unchanged, increment `steps`, go to DONE (normal halt).
  - Else if `tr_next_state` is not one-hot: no tape, head or state update; set `fault`; go to DONE.
  - Else if the move would leave [0, TAPE_LEN-1]: write the symbol, update the state, leave the head unchanged, increment `steps`, set `fault`, go to DONE.
  - Else: write the symbol, update the state, move the head by ±1, increment `steps`. If `steps` now equals `MAX_STEPS`, set `timeout` and go to DONE; otherwise go to FETCH.
- DONE: `done`=1. `start` restarts exactly as from IDLE; tape contents are kept. `load_en` is honoured.
- `busy` = (FETCH or EXEC). While busy, `start` and `load_en` are ignored.
- Symbols are opaque 3-bit values; the valid set is 000 (blank), 001, 010, 100, 101. Invalid codes are passed through unchecked.
- `steps` never wraps; `timeout` guarantees it stops at `MAX_STEPS`.

## Timing
- Reset (async assert, sync deassert by the surrounding design):
  - FSM=IDLE, `tr_state`=`START_STATE`, `head`=`START_HEAD`, symbol reg=000, `steps`=0, all flags 0.
  - Tape cells = 000.
- One machine step = 2 cycles (FETCH, EXEC). `busy` rises the cycle after `start`.
- A run of N steps ending in a normal halt takes `start` + 2N cycles, with `done` asserted in the cycle after the last EXEC.
- Tape write, state, head and `steps` update together on the EXEC clock edge.
- `rd_sym` reflects a load in the cycle after `load_en`.
- Reset mid-run aborts immediately to the reset values, including clearing the tape.

## Structure
- Package `utm_pkg`:
  - `SYM_W`=3, `STATE_W`=8, `HALT_STATE`=8'h00.
  - Symbol constants `SYM_BLANK`, `SYM_1`, `SYM_2`, `SYM_4`, `SYM_5`.
  - FSM enum, step-counter width.
- Sub-module `utm_tape`: TAPE_LEN×3 register array with async reset, one write port (muxed load/EXEC) and two combinational read ports (head, readback).
- The transition logic stays external, so the sequencer is table-agnostic.

## Test plan
- Reset, then load cells 0..3 = 001,010,100,101 -> `rd_sym` returns each value; `busy`=0, `done`=0, `head`=0, `tr_state`=8'h01.
- Stub transition: A with any symbol -> next 8'h00, write 101, move right; `start` -> `done` 3 cycles after `start`, `steps`=1, tape[0]=101, `head`=0, `fault`=0.
- Stub: always state 8'h02, write 001, move right, tape blank -> head advances 0..15; on the 16th EXEC `fault`=1, `head`=15, `steps`=16, tape[0..15]=001.
- Stub returns 8'h03 on the first step -> `fault`=1, `steps`=0, tape and head unchanged, `tr_state`=8'h01.
- `MAX_STEPS`=5 with a non-halting stub ping-ponging the head 0↔1 -> `timeout`=1, `steps`=5, `done` 11 cycles after `start`; `load_en` and `start` pulses mid-run have no effect.
- Assert `rst_n` low during EXEC of step 3 -> all outputs return to their reset values immediately and the tape is all 000; a new `start` then runs from state A at head 0.
